// File: rtl/disp_pkg.sv
// disp_pkg: shared widths, the cost type and arithmetic helpers for the
// disparity stage.
//   PIX_W / COL_W / ROW_W : pixel, column-counter and row-counter widths
//   cost_t                : absolute-difference matching cost
//   absdiff()             : |a - b| on unsigned pixels
//   sat_scale()           : d * gain, saturated to the 8-bit output range
package disp_pkg;

    localparam int PIX_W = 8;
    localparam int COL_W = 9;
    localparam int ROW_W = 8;

    typedef logic [PIX_W-1:0] pix_t;
    typedef logic [PIX_W-1:0] cost_t;

    function automatic cost_t absdiff(input pix_t a, input pix_t b);
        return (a > b) ? cost_t'(a - b) : cost_t'(b - a);
    endfunction

    function automatic pix_t sat_scale(input logic [15:0] d, input logic [15:0] gain);
        logic [31:0] prod;
        prod = {16'd0, d} * {16'd0, gain};
        return (prod > 32'd255) ? 8'hFF : prod[7:0];
    endfunction

endpackage

// File: rtl/disp_argmin.sv
// disp_argmin: per-lane minimum-cost search (second pipeline stage).
//   HCLK, HRESETn : clock, async active-low reset
//   vld_i         : the costs presented this cycle belong to a real beat
//   cost_i        : NCAND registered costs, index = candidate disparity
//   mask_i        : candidate valid bits (bit d set when p-d >= 0)
//   d_o           : registered winning disparity, 0 when vld_i was low
module disp_argmin
    import disp_pkg::*;
#(
    parameter int NCAND = 17,
    parameter int IDX_W = $clog2(NCAND)
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic                     vld_i,
    input  cost_t [NCAND-1:0]        cost_i,
    input  logic  [NCAND-1:0]        mask_i,
    output logic  [IDX_W-1:0]        d_o
);

    cost_t            best_c;
    logic [IDX_W-1:0] best_d;
    logic             found;
    logic [IDX_W-1:0] d_q;

    // Linear scan from d = 0 upward; strict '<' keeps the lowest index on
    // equal cost.
    always_comb begin
        best_c = '1;
        best_d = '0;
        found  = 1'b0;
        for (int d = 0; d < NCAND; d++) begin
            if (mask_i[d] && (!found || (cost_i[d] < best_c))) begin
                best_c = cost_i[d];
                best_d = IDX_W'(d);
                found  = 1'b1;
            end
        end
    end

    // Forcing 0 on idle beats makes the scaled output 0 during gaps.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            d_q <= '0;
        end else begin
            d_q <= vld_i ? best_d : '0;
        end
    end

    assign d_o = d_q;

endmodule

// File: rtl/disparity_stream.sv
// disparity_stream: streaming block-free stereo matcher, 2 pixels per beat.
//   HCLK, HRESETn          : clock, async active-low reset
//   VSYNC_IN               : frame start, holds the row counter at 0
//   HSYNC_IN               : input beat valid
//   DATA_0_L / DATA_1_L    : left pixels, columns x / x+1
//   DATA_0_R / DATA_1_R    : right pixels, columns x / x+1
//   HSYNC_OUT              : HSYNC_IN delayed by 2 cycles
//   DISP_0 / DISP_1        : min(d*SCALE, 255) for columns x / x+1
//   frame_done             : pulse with the output beat of the last pixel pair
// Pipeline: costs and masks are registered (stage 1), the argmin is
// registered inside disp_argmin (stage 2) and scaled on the way out.
module disparity_stream
    import disp_pkg::*;
#(
    parameter int WIDTH    = 320,
    parameter int HEIGHT   = 240,
    parameter int MAX_DISP = 16,   // must be >= 2
    parameter int SCALE    = 16
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             VSYNC_IN,
    input  logic             HSYNC_IN,
    input  logic [PIX_W-1:0] DATA_0_L,
    input  logic [PIX_W-1:0] DATA_1_L,
    input  logic [PIX_W-1:0] DATA_0_R,
    input  logic [PIX_W-1:0] DATA_1_R,
    output logic             HSYNC_OUT,
    output logic [PIX_W-1:0] DISP_0,
    output logic [PIX_W-1:0] DISP_1,
    output logic             frame_done
);

    localparam int NCAND = MAX_DISP + 1;
    localparam int IDX_W = $clog2(NCAND);
    localparam int LANES = 2;

    // ---------------------------------------------------------------
    // Position tracking
    // ---------------------------------------------------------------
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             last_col;
    logic             last_beat;

    assign last_col = (col_q == COL_W'(WIDTH - 2));
    // VSYNC_IN makes the current beat count as row 0.
    assign last_beat = HSYNC_IN && last_col && !VSYNC_IN
                       && (row_q == ROW_W'(HEIGHT - 1));

    always_comb begin
        col_d = '0;
        if (HSYNC_IN && !last_col) begin
            col_d = col_q + COL_W'(2);
        end
        row_d = row_q;
        if (VSYNC_IN) begin
            row_d = '0;
        end else if (HSYNC_IN && last_col) begin
            row_d = (row_q == ROW_W'(HEIGHT - 1)) ? '0 : row_q + ROW_W'(1);
        end
    end

    // ---------------------------------------------------------------
    // Right-pixel history: hist_q[0] is column x-1, hist_q[k] is x-1-k.
    // ---------------------------------------------------------------
    pix_t [MAX_DISP-1:0] hist_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            col_q  <= '0;
            row_q  <= '0;
            hist_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            if (HSYNC_IN) begin
                hist_q[0] <= DATA_1_R;
                hist_q[1] <= DATA_0_R;
                for (int k = 2; k < MAX_DISP; k++) begin
                    hist_q[k] <= hist_q[k-2];
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Stage 1: costs and valid masks for both lanes
    // ---------------------------------------------------------------
    cost_t [LANES-1:0][NCAND-1:0] cost_d, cost_q;
    logic  [LANES-1:0][NCAND-1:0] mask_d, mask_q;
    logic  [1:0]                  vld_pipe_q;   // [0]: stage 1, [1]: stage 2
    logic  [1:0]                  fd_pipe_q;

    for (genvar ln = 0; ln < LANES; ln++) begin : g_lane_cost
        for (genvar d = 0; d < NCAND; d++) begin : g_cand
            // Right column for lane ln, candidate d is x + (ln - d).
            pix_t r_pix;
            pix_t l_pix;
            if (ln - d == 1) begin : g_r1
                assign r_pix = DATA_1_R;
            end else if (ln - d == 0) begin : g_r0
                assign r_pix = DATA_0_R;
            end else begin : g_rh
                assign r_pix = hist_q[d-ln-1];
            end
            if (ln == 0) begin : g_l0
                assign l_pix = DATA_0_L;
            end else begin : g_l1
                assign l_pix = DATA_1_L;
            end
            assign cost_d[ln][d] = absdiff(l_pix, r_pix);
            // History left over from a previous row is never consulted.
            assign mask_d[ln][d] = ((int'(col_q) + ln) >= d);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cost_q     <= '0;
            mask_q     <= '0;
            vld_pipe_q <= '0;
            fd_pipe_q  <= '0;
        end else begin
            cost_q     <= cost_d;
            mask_q     <= mask_d;
            vld_pipe_q <= {vld_pipe_q[0], HSYNC_IN};
            fd_pipe_q  <= {fd_pipe_q[0], last_beat};
        end
    end

    // ---------------------------------------------------------------
    // Stage 2: per-lane argmin, then scale on the way out
    // ---------------------------------------------------------------
    logic [LANES-1:0][IDX_W-1:0] win;

    for (genvar ln = 0; ln < LANES; ln++) begin : g_lane_min
        disp_argmin #(
            .NCAND (NCAND)
        ) u_argmin (
            .HCLK    (HCLK),
            .HRESETn (HRESETn),
            .vld_i   (vld_pipe_q[0]),
            .cost_i  (cost_q[ln]),
            .mask_i  (mask_q[ln]),
            .d_o     (win[ln])
        );
    end

    assign HSYNC_OUT  = vld_pipe_q[1];
    assign frame_done = fd_pipe_q[1];
    assign DISP_0     = sat_scale(16'(win[0]), 16'(SCALE));
    assign DISP_1     = sat_scale(16'(win[1]), 16'(SCALE));

endmodule

// File: tb/tb_disparity_stream.sv
// Directed bench for disparity_stream. Each beat's expected output is
// queued when driven and compared once it emerges from the pipeline.
module tb_disparity_stream;

    localparam int WIDTH    = 320;
    localparam int HEIGHT   = 240;
    localparam int MAX_DISP = 16;
    localparam int SCALE    = 16;
    localparam int BEATS    = WIDTH / 2;

    logic       HCLK = 1'b0;
    logic       HRESETn = 1'b0;
    logic       VSYNC_IN = 1'b0;
    logic       HSYNC_IN = 1'b0;
    logic [7:0] DATA_0_L = '0, DATA_1_L = '0, DATA_0_R = '0, DATA_1_R = '0;
    logic       HSYNC_OUT;
    logic [7:0] DISP_0, DISP_1;
    logic       frame_done;

    always #5 HCLK = ~HCLK;

    disparity_stream #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .MAX_DISP(MAX_DISP), .SCALE(SCALE)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .VSYNC_IN(VSYNC_IN), .HSYNC_IN(HSYNC_IN),
        .DATA_0_L(DATA_0_L), .DATA_1_L(DATA_1_L),
        .DATA_0_R(DATA_0_R), .DATA_1_R(DATA_1_R),
        .HSYNC_OUT(HSYNC_OUT), .DISP_0(DISP_0), .DISP_1(DISP_1),
        .frame_done(frame_done)
    );

    typedef struct packed {
        logic       hs;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       fd;
    } exp_t;

    exp_t       expq[$];
    int         errors = 0;
    int         checks = 0;
    int         fd_seen = 0;
    string      phase = "";
    logic [7:0] rnd_l [WIDTH];
    logic [7:0] rnd_r [WIDTH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s %s: observed=%0d expected=%0d", phase, tag, obs, exp);
        end
    endtask

    // Patterns: 0 flat 100, 1 ramp with right shifted by s, 2 tie, 3 random.
    function automatic logic [7:0] pix_l(input int kind, input int x);
        case (kind)
            0:       return 8'd100;
            1:       return 8'(x);
            2:       return 8'd50;
            default: return rnd_l[x];
        endcase
    endfunction

    function automatic logic [7:0] pix_r(input int kind, input int s, input int x);
        case (kind)
            0:       return 8'd100;
            1:       return 8'(x + s);
            2:       return (x % 2 == 0) ? 8'd40 : 8'd70;
            default: return rnd_r[x];
        endcase
    endfunction

    function automatic logic [7:0] sat(input int v);
        return (v > 255) ? 8'd255 : 8'(v);
    endfunction

    // Brute-force search straight from the matching definition.
    function automatic logic [7:0] ref_disp(input int x);
        int best, bd, c;
        best = 1000;
        bd   = 0;
        for (int d = 0; d <= MAX_DISP && d <= x; d++) begin
            c = int'(rnd_l[x]) - int'(rnd_r[x-d]);
            if (c < 0) c = -c;
            if (c < best) begin
                best = c;
                bd   = d;
            end
        end
        return sat(bd * SCALE);
    endfunction

    function automatic logic [7:0] exp_disp(input int kind, input int s, input int x);
        case (kind)
            0:       return 8'd0;
            1:       return sat(((x < s) ? x : s) * SCALE);
            2:       return (x % 2 == 1) ? 8'd16 : 8'd0;
            default: return ref_disp(x);
        endcase
    endfunction

    task automatic step(input logic hs, input logic vs,
                        input logic [7:0] l0, input logic [7:0] l1,
                        input logic [7:0] r0, input logic [7:0] r1,
                        input exp_t e);
        exp_t c;
        HSYNC_IN = hs;
        VSYNC_IN = vs;
        DATA_0_L = l0;
        DATA_1_L = l1;
        DATA_0_R = r0;
        DATA_1_R = r1;
        expq.push_back(e);
        @(posedge HCLK);
        #1;
        c = expq.pop_front();
        chk("HSYNC_OUT", 32'(HSYNC_OUT), 32'(c.hs));
        chk("DISP_0", 32'(DISP_0), 32'(c.d0));
        chk("DISP_1", 32'(DISP_1), 32'(c.d1));
        chk("frame_done", 32'(frame_done), 32'(c.fd));
        if (frame_done) fd_seen++;
    endtask

    task automatic idle(input int n);
        exp_t z;
        z = '0;
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), z);
        end
    endtask

    task automatic send_row(input int kind, input int s, input int nbeats,
                            input logic vs, input logic last_row);
        exp_t e;
        int   x;
        for (int b = 0; b < nbeats; b++) begin
            x    = 2 * b;
            e.hs = 1'b1;
            e.d0 = exp_disp(kind, s, x);
            e.d1 = exp_disp(kind, s, x + 1);
            e.fd = last_row && (b == BEATS - 1);
            step(1'b1, vs && (b == 0), pix_l(kind, x), pix_l(kind, x + 1),
                 pix_r(kind, s, x), pix_r(kind, s, x + 1), e);
        end
    endtask

    initial begin
        exp_t z;
        z = '0;
        for (int x = 0; x < WIDTH; x++) begin
            rnd_l[x] = 8'($urandom_range(0, 255));
            rnd_r[x] = 8'($urandom_range(0, 255));
        end

        phase = "reset";
        #12;
        chk("HSYNC_OUT", 32'(HSYNC_OUT), 32'd0);
        chk("DISP_0", 32'(DISP_0), 32'd0);
        chk("DISP_1", 32'(DISP_1), 32'd0);
        chk("frame_done", 32'(frame_done), 32'd0);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        expq.push_back(z);
        idle(2);

        phase = "random";   send_row(3, 0, BEATS, 1'b1, 1'b0);  idle(2);
        phase = "tie";      send_row(2, 0, BEATS, 1'b0, 1'b0);  idle(2);
        phase = "saturate"; send_row(1, 16, BEATS, 1'b0, 1'b0); idle(2);
        phase = "partial";  send_row(1, 4, 10, 1'b0, 1'b0);     idle(3);
        phase = "ramp4";    send_row(1, 4, BEATS, 1'b0, 1'b0);  idle(2);
        phase = "flat";
        repeat (6) begin
            send_row(0, 0, BEATS, 1'b0, 1'b0);
            idle(2);
        end

        // Reset lands mid-row while results are non-zero and valid.
        phase = "midreset";
        send_row(1, 4, 50, 1'b0, 1'b0);
        HRESETn = 1'b0;
        #1;
        chk("HSYNC_OUT", 32'(HSYNC_OUT), 32'd0);
        chk("DISP_0", 32'(DISP_0), 32'd0);
        chk("DISP_1", 32'(DISP_1), 32'd0);
        chk("frame_done", 32'(frame_done), 32'd0);
        HSYNC_IN = 1'b0;
        @(posedge HCLK);
        #1;
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        expq.delete();
        expq.push_back(z);

        // No VSYNC here: frame_done on the 240th row relies on reset
        // having cleared the row counter.
        phase = "frame";
        fd_seen = 0;
        for (int r = 0; r < HEIGHT; r++) begin
            send_row((r == 0) ? 1 : 0, 4, BEATS, 1'b0, r == HEIGHT - 1);
            idle(2);
        end
        chk("fd_count", 32'(fd_seen), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
